// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: instruction fetch and load/store share one memory.
// Optional wait-state watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_done_o,
    output logic              fetch_stall_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_done_o,
    output logic              data_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdy_i,
    output logic              mem_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(32'hDEAD_BEEF);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              instr_done_q, instr_done_d;
    logic              data_done_q, data_done_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              grant_data_s;
    logic              grant_instr_s;
    logic              timeout_hit_s;
    logic              wait_clr_s;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;

    assign timeout_hit_s = (state_q != IDLE) && !mem_rdy_i && (wait_cnt_q == WAIT_LAST);

    // Wait-state counter and sticky error flag next state
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        if (wait_clr_s) begin
            wait_cnt_d = '0;
        end else if ((state_q != IDLE) && !mem_rdy_i) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        if (timeout_hit_s) begin
            mem_err_d = 1'b1;
        end else begin
            mem_err_d = mem_err_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err_o = mem_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign mem_err_o     = 1'b0;
`endif

    // Data has priority until it has taken MAX_DATA_BURST grants over a waiting fetch
    assign grant_data_s  = data_req_i && !(instr_req_i && (burst_cnt_q == BURST_MAX));
    assign grant_instr_s = instr_req_i && !grant_data_s;
    assign wait_clr_s    = (state_q == IDLE) && (grant_data_s || grant_instr_s);

    // Arbitration FSM next state and registered-output next values
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        instr_done_d  = 1'b0;
        data_done_d   = 1'b0;
        burst_cnt_d   = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_data_s) begin
                    state_d     = WAIT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_addr_d  = data_addr_i;
                    mem_wdata_d = data_wdata_i;
                    if (!instr_req_i) begin
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end else begin
                        burst_cnt_d = burst_cnt_q;
                    end
                end else if (grant_instr_s) begin
                    state_d     = WAIT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = instr_addr_i;
                    burst_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_I: begin
                if (mem_rdy_i) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    instr_rdata_d = mem_rdata_i;
                    instr_done_d  = 1'b1;
                end else if (timeout_hit_s) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    instr_rdata_d = TIMEOUT_RDATA;
                    instr_done_d  = 1'b1;
                end else begin
                    state_d = WAIT_I;
                end
            end
            WAIT_D: begin
                if (mem_rdy_i) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    data_done_d = 1'b1;
                    if (!mem_we_q) begin
                        data_rdata_d = mem_rdata_i;
                    end else begin
                        data_rdata_d = data_rdata_q;
                    end
                end else if (timeout_hit_s) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    data_done_d = 1'b1;
                    if (!mem_we_q) begin
                        data_rdata_d = TIMEOUT_RDATA;
                    end else begin
                        data_rdata_d = data_rdata_q;
                    end
                end else begin
                    state_d = WAIT_D;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Arbiter state and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            burst_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            instr_done_q  <= instr_done_d;
            data_done_q   <= data_done_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign instr_rdata_o = instr_rdata_q;
    assign data_rdata_o  = data_rdata_q;
    assign instr_done_o  = instr_done_q;
    assign data_done_o   = data_done_q;
    assign fetch_stall_o = instr_req_i & ~instr_done_q;
    assign data_stall_o  = data_req_i & ~data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_DATA_BURST=4, TIMEOUT_CYCLES=8).
// The stuck-memory step follows whichever build ARB_TIMEOUT_EN selects.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_done;
    logic        fetch_stall;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        data_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_drd;
    logic [31:0] exp_addr;
    logic        exp_is_d;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_rdata_o(instr_rdata), .instr_done_o(instr_done), .fetch_stall_o(fetch_stall),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_done_o(data_done),
        .data_stall_o(data_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_rdy_i(mem_rdy),
        .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_rdata = 32'h0; mem_rdy = 1'b0;
        #12;
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_instr_rdata", 64'(instr_rdata), 64'h0);
        check("rst_data_done", 64'(data_done), 64'h0);
        check("rst_mem_err", 64'(mem_err), 64'h0);
        rst_n = 1'b1;
        step();

        // Fetch with zero wait states
        instr_req = 1'b1; instr_addr = 32'h10;
        #1;
        check("f_stall_c0", 64'(fetch_stall), 64'h1);
        step();
        check("f_mem_req_c1", 64'(mem_req), 64'h1);
        check("f_mem_addr", 64'(mem_addr), 64'h10);
        check("f_mem_we", 64'(mem_we), 64'h0);
        check("f_stall_c1", 64'(fetch_stall), 64'h1);
        mem_rdy = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        check("f_done_c2", 64'(instr_done), 64'h1);
        check("f_rdata", 64'(instr_rdata), 64'h1234_5678);
        check("f_stall_c2", 64'(fetch_stall), 64'h0);
        check("f_mem_req_c2", 64'(mem_req), 64'h0);
        check("f_data_done", 64'(data_done), 64'h0);
        instr_req = 1'b0; mem_rdy = 1'b0;
        step();
        check("f_done_pulse", 64'(instr_done), 64'h0);

        // Both requesters held: D,D,D,D,I,D,D,D,D,I
        instr_req = 1'b1; instr_addr = 32'h100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200; mem_rdy = 1'b1;
        exp_drd = 32'h0;
        for (int i = 0; i < 10; i++) begin
            exp_is_d = (i % 5) != 4;
            exp_addr = exp_is_d ? 32'h200 : 32'h100;
            step();
            check($sformatf("arb_addr_%0d", i), 64'(mem_addr), 64'(exp_addr));
            mem_rdata = 32'hA000_0000 + 32'(i);
            if (exp_is_d) exp_drd = mem_rdata;
            step();
            check($sformatf("arb_ddone_%0d", i), 64'(data_done), 64'(exp_is_d));
            check($sformatf("arb_idone_%0d", i), 64'(instr_done), 64'(!exp_is_d));
        end
        check("arb_drdata", 64'(data_rdata), 64'(exp_drd));
        check("arb_irdata", 64'(instr_rdata), 64'hA000_0009);
        instr_req = 1'b0; data_req = 1'b0; mem_rdy = 1'b0;
        step();

        // Store with three wait states; inputs wiggle during the wait
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'hCAFE_F00D;
        step();
        data_addr = 32'h99; data_wdata = 32'h1; data_we = 1'b0; instr_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("st_req_c%0d", c), 64'(mem_req), 64'h1);
            check($sformatf("st_we_c%0d", c), 64'(mem_we), 64'h1);
            check($sformatf("st_addr_c%0d", c), 64'(mem_addr), 64'h40);
            check($sformatf("st_wdata_c%0d", c), 64'(mem_wdata), 64'hCAFE_F00D);
            check($sformatf("st_done_c%0d", c), 64'(data_done), 64'h0);
            if (c == 4) begin
                mem_rdy = 1'b1; mem_rdata = 32'h0BAD_0BAD;
            end
            step();
        end
        check("st_done_c5", 64'(data_done), 64'h1);
        check("st_rdata_kept", 64'(data_rdata), 64'(exp_drd));
        check("st_idone", 64'(instr_done), 64'h0);
        check("st_req_drop", 64'(mem_req), 64'h0);
        data_req = 1'b0; instr_req = 1'b0; mem_rdy = 1'b0;
        step();

        // Reset during WAIT_D, then a normal fetch
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
        step();
        check("rw_req_up", 64'(mem_req), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_req_async", 64'(mem_req), 64'h0);
        check("rw_addr", 64'(mem_addr), 64'h0);
        check("rw_drdata", 64'(data_rdata), 64'h0);
        check("rw_irdata", 64'(instr_rdata), 64'h0);
        data_req = 1'b0;
        step();
        rst_n = 1'b1;
        instr_req = 1'b1; instr_addr = 32'h0;
        step();
        check("rw_f_req", 64'(mem_req), 64'h1);
        check("rw_f_addr", 64'(mem_addr), 64'h0);
        mem_rdy = 1'b1; mem_rdata = 32'h0000_1337;
        step();
        check("rw_f_done", 64'(instr_done), 64'h1);
        check("rw_f_rdata", 64'(instr_rdata), 64'h0000_1337);
        instr_req = 1'b0; mem_rdy = 1'b0;
        step();

        // Load against a memory that never answers
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
        step();
        data_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) step();
        check("to_req_c8", 64'(mem_req), 64'h1);
        check("to_done_c8", 64'(data_done), 64'h0);
        step();
        check("to_done", 64'(data_done), 64'h1);
        check("to_rdata", 64'(data_rdata), 64'hDEAD_BEEF);
        check("to_err", 64'(mem_err), 64'h1);
        check("to_req_drop", 64'(mem_req), 64'h0);
        for (int c = 0; c < 5; c++) step();
        check("to_err_sticky", 64'(mem_err), 64'h1);
`else
        for (int c = 0; c < 110; c++) step();
        check("hold_req", 64'(mem_req), 64'h1);
        check("hold_addr", 64'(mem_addr), 64'h300);
        check("hold_done", 64'(data_done), 64'h0);
        check("hold_err", 64'(mem_err), 64'h0);
        mem_rdy = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        check("hold_cpl_done", 64'(data_done), 64'h1);
        check("hold_cpl_rdata", 64'(data_rdata), 64'h5555_AAAA);
        check("hold_cpl_err", 64'(mem_err), 64'h0);
`endif
        mem_rdy = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter sharing one 32-bit memory between the instruction-fetch path and the data (load/store) path. It sits between the fetch unit and memory on one side, the MEM stage on the other, and one memory interface with variable latency. It sequences each access through a request/ready handshake, prioritises data with a starvation guard for fetch, and generates per-requester stall signals for the hazard logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT_CYCLES, 255, wait-state limit (only with ARB_TIMEOUT_EN)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- instr_req  in  1  fetch request, level, held until instr_done
- instr_addr  in  ADDR_W  fetch address (PC), stable while instr_req
- instr_rdata  out  DATA_W  fetched instruction, registered
- instr_done  out  1  one-cycle pulse, instr_rdata valid
- fetch_stall  out  1  instr_req & ~instr_done
- data_req  in  1  load/store request, level, held until data_done
- data_we  in  1  1 = store, 0 = load
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data, registered
- data_done  out  1  one-cycle pulse, access complete
- data_stall  out  1  data_req & ~data_done
- mem_req  out  1  memory access request, held until mem_rdy
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid when mem_rdy
- mem_rdy  in  1  memory completes current access this cycle
- mem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT_I, WAIT_D.
- IDLE: sample requests each edge. None -> stay. Grant chosen, then mem_addr/mem_we/mem_wdata registered, mem_req=1, go WAIT_I or WAIT_D.
- Grant rule: data wins unless instr_req=1 and burst_cnt==MAX_DATA_BURST; then instruction wins.
- burst_cnt: +1 on each data grant while instr_req=1; cleared on instruction grant or when instr_req=0 at a data grant; saturates at MAX_DATA_BURST.
- Instruction grant forces mem_we=0, mem_wdata unchanged.
- WAIT_x: mem_req and mem_* held stable. Edge with mem_rdy=1: capture mem_rdata into owner's rdata register (loads/fetches; stores leave data_rdata unchanged), pulse owner's done, drop mem_req, go IDLE.
- Requester sees done in the cycle after mem_rdy; request still high at end of that cycle is a new request.
- Non-owner rdata/done unaffected.
- Reset (asserted any time, incl. mid-access): immediate return to IDLE; mem_req, mem_we, mem_addr, mem_wdata, instr_rdata, data_rdata, instr_done, data_done, burst_cnt, wait counter, mem_err all 0. Memory discards an in-flight access whose mem_req drops.
- Inputs changing during WAIT_x ignored until IDLE.

## Timing
- Minimum access: request high at cycle 0 edge -> mem_req cycle 1 -> mem_rdy in cycle 1 -> done in cycle 2. Latency = 2 + wait states.
- Max throughput: one access per 2 cycles (IDLE cycle between accesses).
- fetch_stall/data_stall combinational from req and registered done; no input-to-mem_* combinational path.
- mem_rdy ignored in IDLE.

## Configuration
- ARB_TIMEOUT_EN defined: wait counter clears on grant, increments each WAIT cycle without mem_rdy; reaching TIMEOUT_CYCLES drops mem_req, pulses owner's done with rdata = 32'hDEADBEEF (stores: rdata unchanged), sets mem_err until reset, returns IDLE.
- Not defined: no counter; WAIT_x held indefinitely; mem_err tied 0.

## Test plan
- Fetch only, mem_rdy 0 wait: instr_addr=0x10, mem_rdata=0x12345678 -> mem_req cycle 1, instr_done cycle 2, instr_rdata=0x12345678, fetch_stall high cycles 0-1.
- Simultaneous req, MAX_DATA_BURST=4, data held continuously: grants D,D,D,D,I,D,...; instruction never starved beyond 4 data accesses.
- Store data_addr=0x40 data_wdata=0xCAFEF00D, 3 wait states -> mem_we=1, mem_* stable 4 cycles, data_done cycle 5, data_rdata unchanged.
- Reset asserted in WAIT_D -> mem_req falls without clock edge, all outputs 0; after release fetch at 0x0 proceeds normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_rdy stuck 0 on load -> data_done after 8 wait cycles, data_rdata=0xDEADBEEF, mem_err=1 until reset.
- Without ARB_TIMEOUT_EN, same stimulus -> stays WAIT_D 100+ cycles, mem_err=0; mem_rdy=1 then completes normally.
